// File: rtl/alu_issue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_issue_pkg                                          |
// | Description : Shared opcodes, field positions, FSM states and the    |
// |               instruction record used by the ALU issue sequencer.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_issue_pkg;

    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [3:0] OP_ILL_LO = 4'd12;
    localparam logic [3:0] OP_ILL_HI = 4'd14;

    // Instruction word field positions
    localparam int FUNC_MSB = 23;
    localparam int FUNC_LSB = 20;
    localparam int RD_MSB   = 19;
    localparam int RD_LSB   = 16;
    localparam int RS1_MSB  = 15;
    localparam int RS1_LSB  = 12;
    localparam int RS2_MSB  = 11;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_STALL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] addr;
    } instr_t;

    function automatic instr_t decode(input logic [23:0] w);
        instr_t d;
        d.func = w[FUNC_MSB:FUNC_LSB];
        d.rd   = w[RD_MSB:RD_LSB];
        d.rs1  = w[RS1_MSB:RS1_LSB];
        d.rs2  = w[RS2_MSB:RS2_LSB];
        d.addr = w[ADDR_MSB:ADDR_LSB];
        return d;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_hazard_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_hazard_det                                         |
// | Description : Read-after-write check of both source selects against  |
// |               the destination of the instruction issued last cycle.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_hazard_det (
    input  logic [3:0] i_rs1,
    input  logic [3:0] i_rs2,
    input  logic [3:0] i_last_rd,
    input  logic       i_last_valid,
    output logic       o_hazard
);

    // Conservative: both sources compared whatever the opcode uses
    assign o_hazard = i_last_valid && ((i_rs1 == i_last_rd) || (i_rs2 == i_last_rd));

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_issue                                              |
// | Description : Fetch/issue sequencer for the pipelined ALU: one       |
// |               instruction per cycle, one-bubble RAW stall, HALT stop.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [23:0]        imem_rdata,
    output logic               issue_valid,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [3:0]         rd,
    output logic [3:0]         func,
    output logic [7:0]         addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        stall_cnt
);

    state_t             r_state, w_state_nxt;
    logic [IMEM_AW-1:0] r_pc, w_pc_nxt;
    instr_t             r_hold, w_hold_nxt;
    instr_t             r_issue, w_issue_nxt;
    logic               r_issue_valid, w_issue_valid_nxt;
    logic [3:0]         r_last_rd, w_last_rd_nxt;
    logic               r_last_valid, w_last_valid_nxt;
    logic               r_err, w_err_nxt;
    logic [15:0]        r_stall_cnt, w_stall_cnt_nxt;

    instr_t             w_instr;
    logic               w_hazard;

    assign w_instr = decode(imem_rdata);

    alu_hazard_det u_hazard (
        .i_rs1        (w_instr.rs1),
        .i_rs2        (w_instr.rs2),
        .i_last_rd    (r_last_rd),
        .i_last_valid (r_last_valid),
        .o_hazard     (w_hazard)
    );

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values; issue defaults to a bubble
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_hold_nxt        = r_hold;
        w_issue_nxt       = '0;
        w_issue_valid_nxt = 1'b0;
        w_last_rd_nxt     = r_last_rd;
        w_last_valid_nxt  = r_last_valid;
        w_err_nxt         = r_err;
        w_stall_cnt_nxt   = r_stall_cnt;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_pc_nxt         = '0;
                    w_stall_cnt_nxt  = '0;
                    w_err_nxt        = 1'b0;
                    w_last_valid_nxt = 1'b0;
                    w_state_nxt      = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // Address 0 is in flight; next cycle imem_rdata holds instr[0]
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_instr.func == OP_HALT) begin
                    w_state_nxt = ST_DONE;
                end else if (is_illegal(w_instr.func)) begin
                    w_err_nxt        = 1'b1;
                    w_pc_nxt         = r_pc + 1'b1;
                    w_last_valid_nxt = 1'b0;
                end else if (w_hazard) begin
                    // pc held: the fetch already in flight is consumed in STALL
                    w_hold_nxt       = w_instr;
                    w_last_valid_nxt = 1'b0;
                    w_state_nxt      = ST_STALL;
                    if (r_stall_cnt != 16'hFFFF) begin
                        w_stall_cnt_nxt = r_stall_cnt + 16'd1;
                    end
                end else begin
                    w_issue_nxt       = w_instr;
                    w_issue_valid_nxt = 1'b1;
                    w_pc_nxt          = r_pc + 1'b1;
                    w_last_rd_nxt     = w_instr.rd;
                    w_last_valid_nxt  = 1'b1;
                end
            end
            ST_STALL: begin
                // The bubble already separated writer and reader
                w_issue_nxt       = r_hold;
                w_issue_valid_nxt = 1'b1;
                w_last_rd_nxt     = r_hold.rd;
                w_last_valid_nxt  = 1'b1;
                w_pc_nxt          = r_pc + 1'b1;
                w_state_nxt       = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_hold        <= '0;
            r_issue       <= '0;
            r_issue_valid <= 1'b0;
            r_last_rd     <= '0;
            r_last_valid  <= 1'b0;
            r_err         <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_hold        <= w_hold_nxt;
            r_issue       <= w_issue_nxt;
            r_issue_valid <= w_issue_valid_nxt;
            r_last_rd     <= w_last_rd_nxt;
            r_last_valid  <= w_last_valid_nxt;
            r_err         <= w_err_nxt;
            r_stall_cnt   <= w_stall_cnt_nxt;
        end
    end

    assign imem_addr   = r_pc;
    assign issue_valid = r_issue_valid;
    assign func        = r_issue.func;
    assign rd          = r_issue.rd;
    assign rs1         = r_issue.rs1;
    assign rs2         = r_issue.rs2;
    assign addr        = r_issue.addr;
    assign busy        = (r_state == ST_PRIME) || (r_state == ST_RUN) || (r_state == ST_STALL);
    assign done        = (r_state == ST_DONE);
    assign err         = r_err;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_issue                                           |
// | Description : Self-checking bench for alu_issue: directed program    |
// |               table, random programs vs. slot-level reference model, |
// |               PC wrap, start-while-busy and reset-in-stall sequences.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_issue;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        start8, start2;

    logic [7:0]  imem_addr8;
    logic [23:0] rdata8;
    logic        issue_valid;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        busy, done, err;
    logic [15:0] stall_cnt;

    logic [1:0]  imem_addr2;
    logic [23:0] rdata2;
    logic        iv2;
    logic [3:0]  rs1_2, rs2_2, rd_2, func_2;
    logic [7:0]  addr_2;
    logic        busy2, done2, err2;
    logic [15:0] stall2;

    logic [23:0] mem8 [256];
    logic [23:0] mem2 [4];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk1 = ~clk1;

    // Synchronous instruction memories
    always @(posedge clk1) rdata8 <= mem8[imem_addr8];
    always @(posedge clk1) rdata2 <= mem2[imem_addr2];

    alu_issue #(.IMEM_AW(8)) u_dut (
        .clk1(clk1), .rst_n(rst_n), .start(start8),
        .imem_addr(imem_addr8), .imem_rdata(rdata8),
        .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func),
        .addr(addr), .busy(busy), .done(done), .err(err), .stall_cnt(stall_cnt)
    );

    alu_issue #(.IMEM_AW(2)) u_wrap (
        .clk1(clk1), .rst_n(rst_n), .start(start2),
        .imem_addr(imem_addr2), .imem_rdata(rdata2),
        .issue_valid(iv2), .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .func(func_2),
        .addr(addr_2), .busy(busy2), .done(done2), .err(err2), .stall_cnt(stall2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slot-level reference model ----------------
    typedef struct {
        bit          v;
        logic [23:0] w;
        bit          err;
        int          stalls;
        bit          done;
    } slot_t;

    slot_t exp_q[$];

    // One entry per clock edge after the start edge; the first is the priming edge.
    task automatic build_model(input int max_slots);
        int          pc;
        bit          pv, e, fin;
        logic [3:0]  prd;
        int          st;
        logic [23:0] w;
        slot_t       s;
        pc = 0; pv = 0; e = 0; fin = 0; prd = 0; st = 0;
        exp_q.delete();
        s.v = 0; s.w = 0; s.err = 0; s.stalls = 0; s.done = 0;
        exp_q.push_back(s);
        while (exp_q.size() < max_slots) begin
            s.v = 0; s.w = 0;
            if (fin) begin
                s.done = 1; exp_q.push_back(s);
            end else begin
                w  = mem8[pc];
                pc = (pc + 1) % 256;
                if (w[23:20] == 4'hF) begin
                    fin = 1; s.done = 1; exp_q.push_back(s);
                end else if (w[23:20] >= 4'd12) begin
                    e = 1; pv = 0; s.err = e; exp_q.push_back(s);
                end else begin
                    if (pv && (w[15:12] == prd || w[11:8] == prd)) begin
                        st++; s.stalls = st; exp_q.push_back(s);
                    end
                    s.v = 1; s.w = w; s.err = e; s.stalls = st;
                    exp_q.push_back(s);
                    pv = 1; prd = w[19:16];
                end
            end
        end
    endtask

    // Start is raised for the single edge following slot index 'poke'.
    task automatic compare_slots(input string tag, input int poke);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk1); #1;
            chk($sformatf("%s valid[%0d]", tag, i), issue_valid, exp_q[i].v);
            chk($sformatf("%s word[%0d]", tag, i), {func, rd, rs1, rs2, addr},
                exp_q[i].v ? exp_q[i].w : 24'h0);
            chk($sformatf("%s err[%0d]", tag, i), err, exp_q[i].err);
            chk($sformatf("%s stall_cnt[%0d]", tag, i), stall_cnt, exp_q[i].stalls);
            chk($sformatf("%s done[%0d]", tag, i), done, exp_q[i].done);
            chk($sformatf("%s busy[%0d]", tag, i), busy, !exp_q[i].done);
            start8 = (i == poke);
        end
        start8 = 1'b0;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clk1);
        if (which) start2 = 1'b1; else start8 = 1'b1;
        @(negedge clk1);
        start2 = 1'b0; start8 = 1'b0;
    endtask

    task automatic clear_mem8();
        for (int a = 0; a < 256; a++) mem8[a] = 24'hF00000;
    endtask

    // ---------------- directed program table ----------------
    typedef struct {
        logic [23:0] p0, p1, p2, p3;
        int          n_issue;
        int          n_stall;
        bit          err;
        int          done_edge;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    initial begin
        int iss, de, late, L, wi;
        logic [23:0] wd;

        vt[0] = '{24'h001230, 24'h145670, 24'hF00000, 24'hF00000, 2, 0, 1'b0, 4};
        vt[1] = '{24'h3A1200, 24'h0BA100, 24'hF00000, 24'hF00000, 2, 1, 1'b0, 5};
        vt[2] = '{24'h001230, 24'hD00000, 24'h145670, 24'hF00000, 2, 0, 1'b1, 5};
        vt[3] = '{24'hF00000, 24'h001230, 24'h145670, 24'hF00000, 0, 0, 1'b0, 2};
        vt[4] = '{24'h152000, 24'h201500, 24'h300100, 24'hF00000, 3, 2, 1'b0, 7};
        vt[5] = '{24'hC00000, 24'hE11100, 24'hF00000, 24'hF00000, 0, 0, 1'b1, 4};
        vt[6] = '{24'hB12300, 24'hF00000, 24'hF00000, 24'hF00000, 1, 0, 1'b0, 3};

        clear_mem8();
        mem2[0] = 24'h140000; mem2[1] = 24'h250000;
        mem2[2] = 24'h360000; mem2[3] = 24'h470000;
        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;

        // Reset state
        #1;
        chk("rst issue_valid", issue_valid, 0);
        chk("rst fields", {func, rd, rs1, rs2, addr}, 0);
        chk("rst imem_addr", imem_addr8, 0);
        chk("rst busy/done/err", {busy, done, err}, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        @(negedge clk1); @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("idle busy", busy, 0);

        // PC wrap on the 2-bit-address instance, no HALT
        pulse_start(1'b1);
        chk("wrap addr[0]", imem_addr2, 0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk1); #1;
            chk($sformatf("wrap addr[%0d]", k), imem_addr2, k % 4);
            chk($sformatf("wrap valid[%0d]", k), iv2, k >= 2);
            if (k >= 2)
                chk($sformatf("wrap word[%0d]", k), {func_2, rd_2, rs1_2, rs2_2, addr_2},
                    mem2[(k - 2) % 4]);
            chk($sformatf("wrap busy[%0d]", k), busy2, 1);
        end

        // Directed table
        for (int t = 0; t < NV; t++) begin
            clear_mem8();
            mem8[0] = vt[t].p0; mem8[1] = vt[t].p1;
            mem8[2] = vt[t].p2; mem8[3] = vt[t].p3;
            pulse_start(1'b0);
            iss = 0; de = -1; late = 0;
            for (int k = 1; k <= 30; k++) begin
                @(posedge clk1); #1;
                if (issue_valid) begin
                    iss++;
                    if (de >= 0) late = 1;
                end
                if (done && de < 0) de = k;
            end
            chk($sformatf("tbl%0d issues", t), iss, vt[t].n_issue);
            chk($sformatf("tbl%0d stall_cnt", t), stall_cnt, vt[t].n_stall);
            chk($sformatf("tbl%0d err", t), err, vt[t].err);
            chk($sformatf("tbl%0d done_edge", t), de, vt[t].done_edge);
            chk($sformatf("tbl%0d issue_after_done", t), late, 0);
        end

        // Random programs against the reference model
        for (int r = 0; r < 20; r++) begin
            clear_mem8();
            L = $urandom_range(3, 14);
            for (int a = 0; a < L; a++) begin
                wd[23:20] = ($urandom_range(0, 9) == 0) ? 4'(12 + $urandom_range(0, 2))
                                                         : 4'($urandom_range(0, 11));
                wd[19:16] = 4'($urandom_range(0, 3));
                wd[15:12] = 4'($urandom_range(0, 3));
                wd[11:8]  = 4'($urandom_range(0, 3));
                wd[7:0]   = 8'($urandom_range(0, 255));
                mem8[a] = wd;
            end
            build_model(2 * L + 6);
            pulse_start(1'b0);
            compare_slots($sformatf("rnd%0d", r), -1);
        end

        // start pulsed while running must not disturb the sequence
        clear_mem8();
        for (int a = 0; a < 8; a++) begin
            wi = a % 3;
            mem8[a] = {4'(a % 12), 4'(wi), 4'(wi), 4'((wi + 2) % 3), 8'(a * 17)};
        end
        build_model(24);
        pulse_start(1'b0);
        compare_slots("poke", 3);

        // Reset while in STALL, then restart from address 0
        clear_mem8();
        mem8[0] = 24'h3A1200; mem8[1] = 24'h0BA100;
        pulse_start(1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk1); #1;
        end
        chk("stall pre-reset stall_cnt", stall_cnt, 1);
        chk("stall pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst issue_valid", issue_valid, 0);
        chk("mid-rst fields", {func, rd, rs1, rs2, addr}, 0);
        chk("mid-rst imem_addr", imem_addr8, 0);
        chk("mid-rst busy/done/err", {busy, done, err}, 0);
        chk("mid-rst stall_cnt", stall_cnt, 0);
        @(negedge clk1);
        rst_n = 1'b1;
        build_model(8);
        pulse_start(1'b0);
        compare_slots("post-rst", -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
